sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port `ram` instance (registered read, 1-cycle latency) among NUM_REQ requesters using round-robin arbitration with optional burst hold.
- Drives the RAM address, data and write-enable through an internal one-hot-indexed select of the requester fields.
- Returns read data with a one-hot valid tag that identifies the owning requester.
- Sits between the NBin/SB/NBout buffer clients and their shared SRAM bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- REQ_SEL_WIDTH, 2, clog2(NUM_REQ); width of the grant index
- ADDR_WIDTH, 4, RAM address width
- DATA_WIDTH, 32, RAM data width
- MAX_BURST, 4, maximum consecutive grants to one requester while it holds i_burst (1..16)

Ports:
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  per-requester access request, level, held until granted
- i_we  in  NUM_REQ  per-requester write (1) / read (0)
- i_burst  in  NUM_REQ  requester asks to keep ownership for consecutive accesses
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- o_gnt  out  NUM_REQ  one-hot grant; combinational, access occurs at this clock edge
- o_gnt_idx  out  REQ_SEL_WIDTH  binary index of the granted requester (0 when none)
- o_ram_addr  out  ADDR_WIDTH  to ram i_address
- o_ram_data  out  DATA_WIDTH  to ram i_data
- o_ram_we  out  1  to ram i_we
- i_ram_data  in  DATA_WIDTH  from ram o_data
- o_rdata  out  DATA_WIDTH  read data; equals i_ram_data
- o_rvalid  out  NUM_REQ  one-hot, high one cycle after a granted read
- o_busy  out  1  any grant this cycle or read in flight

Behaviour:
- Reset values (async on i_rst_n=0):
  - rr pointer=0, owner valid=0, burst count=0.
  - o_rvalid=0.
  - With no requests: o_gnt=0, o_gnt_idx=0, o_ram_we=0, o_ram_addr=0, o_ram_data=0, o_busy=0.
- Arbitration (combinational, each cycle):
  - If the owner is valid, the owner still requests with i_burst, and burst count < MAX_BURST: grant the owner.
  - Otherwise grant the first requesting index at or after the rr pointer, wrapping modulo NUM_REQ.
  - No request means no grant.
- RAM drive:
  - o_ram_addr and o_ram_data are the granted requester's fields.
  - o_ram_we = granted requester's i_we AND the grant is active.
  - With no grant, address and data are 0 and we is 0.
- Pointer update on each grant to index g:
  - rr pointer <= (g+1) mod NUM_REQ, even during a burst.
  - After a burst ends, the next winner starts its search from the slot after the burst owner.
- Burst counter:
  - Grant to the same owner with i_burst set: count+1.
  - Grant to a new owner: count <= 1.
  - No grant: count <= 0 and owner valid <= 0.
  - Owner valid is set on any grant with i_burst high, and cleared when a grant occurs with i_burst low.
  - When count reaches MAX_BURST, the owner loses priority for exactly one arbitration. If it is the only requester it is re-granted and count restarts at 1.
- Read return:
  - o_rvalid <= o_gnt & ~i_we, registered.
  - o_rdata is valid in the same cycle as o_rvalid. Latency from grant to data is 1 cycle.
- Write-then-read to the same address in back-to-back cycles returns the new data (RAM write precedes its registered read on the next edge).
- Requests dropped without a grant are legal and produce no side effect.
- Reset mid-operation: an in-flight o_rvalid is cleared immediately; the RAM contents are untouched.
- o_busy = |o_gnt | |o_rvalid.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds output o_stall_cnt (16 bits).
  - The counter increments each cycle in which a requester has i_req high but no grant, counted once per cycle regardless of how many requesters stall.
  - Saturates at 16'hFFFF; reset to 0.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single requester read: req[2]=1, we=0, addr=5 with mem[5]=32'hDEADBEEF -> o_gnt=4'b0100 same cycle; next cycle o_rvalid=4'b0100, o_rdata=32'hDEADBEEF.
- Round-robin fairness: all four req held high for 8 cycles, no burst -> grant order 0,1,2,3,0,1,2,3; o_gnt_idx follows.
- Burst cap: MAX_BURST=4, req[1]=req[3]=1, burst[1]=1 -> grants 1,1,1,1,3, then 1; burst count returns to 1.
- Write-then-read: cycle 0 req0 write addr=3 data=32'h12345678; cycle 1 req1 read addr=3 -> cycle 2 o_rvalid=4'b0010, o_rdata=32'h12345678.
- Async reset mid-read: assert i_rst_n=0 between grant and return -> o_rvalid=0 at once; after release, an all-requesting cycle grants requester 0 (pointer reset).
- ARB_STATS_EN: 3 requesters held high for 6 cycles -> o_stall_cnt=6; after reset it reads 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter with burst hold sharing one registered-read SRAM port
// Optional stall counter output o_stall_cnt when ARB_STATS_EN is defined.
module sram_port_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int REQ_SEL_WIDTH = 2,
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BURST     = 4
) (
   input  logic                          clk,
   input  logic                          i_rst_n,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ-1:0]            i_we,
   input  logic [NUM_REQ-1:0]            i_burst,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [REQ_SEL_WIDTH-1:0]      o_gnt_idx,
   output logic [ADDR_WIDTH-1:0]         o_ram_addr,
   output logic [DATA_WIDTH-1:0]         o_ram_data,
   output logic                          o_ram_we,
   input  logic [DATA_WIDTH-1:0]         i_ram_data,
   output logic [DATA_WIDTH-1:0]         o_rdata,
   output logic [NUM_REQ-1:0]            o_rvalid,
   output logic                          o_busy
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]                   o_stall_cnt
`endif
);

   localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

   logic [REQ_SEL_WIDTH-1:0] ptr_q, ptr_d;
   logic [REQ_SEL_WIDTH-1:0] owner_q, owner_d;
   logic                     owner_vld_q, owner_vld_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]       rvalid_q, rvalid_d;

   logic [REQ_SEL_WIDTH-1:0] gnt_idx;
   logic                     gnt_any;
   logic                     hold;
   logic [NUM_REQ-1:0]       gnt;
   logic [ADDR_WIDTH-1:0]    ram_addr;
   logic [DATA_WIDTH-1:0]    ram_data;
   logic                     ram_we;

   // Owner keeps the port only while it still asks for a burst and has not used its quota
   assign hold = owner_vld_q && i_req[owner_q] && i_burst[owner_q]
                 && (cnt_q < CNT_WIDTH'(MAX_BURST));

   always_comb begin : arbitrate
      int idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      if (hold) begin
         gnt_any = 1'b1;
         gnt_idx = owner_q;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!gnt_any && i_req[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = REQ_SEL_WIDTH'(idx);
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // AND-OR select keyed by the one-hot grant; zero fields fall out when nobody is granted
   always_comb begin
      ram_addr = '0;
      ram_data = '0;
      ram_we   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            ram_addr = ram_addr | i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            ram_data = ram_data | i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            ram_we   = ram_we | i_we[k];
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      cnt_d       = cnt_q;
      if (gnt_any) begin
         ptr_d       = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
         owner_d     = gnt_idx;
         owner_vld_d = i_burst[gnt_idx];
         cnt_d       = hold ? cnt_q + 1'b1 : CNT_WIDTH'(1);
      end else begin
         owner_vld_d = 1'b0;
         cnt_d       = '0;
      end
   end

   assign rvalid_d = gnt & ~i_we;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q       <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         cnt_q       <= '0;
         rvalid_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         cnt_q       <= cnt_d;
         rvalid_q    <= rvalid_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] stall_q, stall_d;

   // One count per cycle in which any requester is left waiting
   always_comb begin
      stall_d = stall_q;
      if (|(i_req & ~gnt) && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign o_stall_cnt = stall_q;
`endif

   assign o_gnt      = gnt;
   assign o_gnt_idx  = gnt_idx;
   assign o_ram_addr = ram_addr;
   assign o_ram_data = ram_data;
   assign o_ram_we   = ram_we;
   assign o_rdata    = i_ram_data;
   assign o_rvalid   = rvalid_q;
   assign o_busy     = gnt_any | (|rvalid_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized and directed bench for sram_port_arbiter with grant-history model
module tb_sram_port_arbiter;

   localparam int N   = 4;
   localparam int AW  = 4;
   localparam int DW  = 32;
   localparam int MB  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req, we, burst;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] wdata [N];
   logic [N*AW-1:0] addr_p;
   logic [N*DW-1:0] wdata_p;

   logic [N-1:0]  o_gnt, o_rvalid;
   logic [1:0]    o_gnt_idx;
   logic [AW-1:0] o_ram_addr;
   logic [DW-1:0] o_ram_data, o_rdata;
   logic          o_ram_we, o_busy;
   logic [DW-1:0] ram_q;
`ifdef ARB_STATS_EN
   logic [15:0]   o_stall_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign addr_p[k*AW +: AW]  = addr[k];
      assign wdata_p[k*DW +: DW] = wdata[k];
   end

   sram_port_arbiter #(.NUM_REQ(N), .REQ_SEL_WIDTH(2), .ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_we       (we),
      .i_burst    (burst),
      .i_addr     (addr_p),
      .i_wdata    (wdata_p),
      .o_gnt      (o_gnt),
      .o_gnt_idx  (o_gnt_idx),
      .o_ram_addr (o_ram_addr),
      .o_ram_data (o_ram_data),
      .o_ram_we   (o_ram_we),
      .i_ram_data (ram_q),
      .o_rdata    (o_rdata),
      .o_rvalid   (o_rvalid),
      .o_busy     (o_busy)
`ifdef ARB_STATS_EN
      ,
      .o_stall_cnt(o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 | (i * 32'h111));
   endfunction

   // Registered-read single-port RAM standing in for the shared bank
   logic [DW-1:0] ram [16];
   logic          ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
         ram_ready <= 1'b1;
      end else begin
         if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
         ram_q <= ram[o_ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: arbitration derived from the grant history since reset
   int            hist [$];
   logic [DW-1:0] mmem [16];
   bit            m_init = 1'b0;
   logic [N-1:0]  m_rv;
   logic [DW-1:0] m_rd;
   int            m_stall;
   int            last_g, ptr, own, run, g;

   always @(negedge clk) begin
      if (!m_init) begin
         for (int i = 0; i < 16; i++) mmem[i] = init_val(i);
         m_init = 1'b1;
      end
      if (!rst_n) begin
         hist.delete();
         m_rv    = '0;
         m_stall = 0;
         chk("rst_rvalid", 64'(o_rvalid), 64'(0));
      end else begin
         last_g = -1;
         for (int j = hist.size() - 1; j >= 0; j--) begin
            if (hist[j] >= 0) begin
               last_g = hist[j] >> 1;
               break;
            end
         end
         ptr = (last_g < 0) ? 0 : (last_g + 1) % N;
         own = -1;
         run = 0;
         if (hist.size() > 0 && hist[hist.size()-1] >= 0 && (hist[hist.size()-1] & 1) == 1) begin
            own = hist[hist.size()-1] >> 1;
            for (int j = hist.size() - 1; j >= 0; j--) begin
               if (hist[j] != own * 2 + 1) break;
               run++;
            end
         end
         g = -1;
         if (own >= 0 && (run % MB) != 0 && req[own] && burst[own]) g = own;
         else begin
            for (int i = 0; i < N; i++) begin
               int k;
               k = (ptr + i) % N;
               if (g < 0 && req[k]) g = k;
            end
         end
         chk("gnt",     64'(o_gnt),      (g >= 0) ? 64'(1) << g : 64'(0));
         chk("gnt_idx", 64'(o_gnt_idx),  (g >= 0) ? 64'(g) : 64'(0));
         chk("ram_addr", 64'(o_ram_addr), (g >= 0) ? 64'(addr[g]) : 64'(0));
         chk("ram_data", 64'(o_ram_data), (g >= 0) ? 64'(wdata[g]) : 64'(0));
         chk("ram_we",  64'(o_ram_we),   (g >= 0) ? 64'(we[g]) : 64'(0));
         chk("rvalid",  64'(o_rvalid),   64'(m_rv));
         if (m_rv != 0) chk("rdata", 64'(o_rdata), 64'(m_rd));
         chk("busy",    64'(o_busy),     64'((g >= 0) || (m_rv != 0)));
`ifdef ARB_STATS_EN
         chk("stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
         if (((req & ~((g >= 0) ? (4'b1 << g) : 4'b0)) != 0) && m_stall < 16'hFFFF) m_stall++;
`endif
         m_rv = '0;
         if (g >= 0) begin
            if (!we[g]) begin
               m_rv = 4'b1 << g;
               m_rd = mmem[addr[g]];
            end else begin
               mmem[addr[g]] = wdata[g];
            end
            hist.push_back(g * 2 + int'(burst[g]));
         end else begin
            hist.push_back(-1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      req   = '0;
      burst = '0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_rr [8];
      int exp_bu [6];
      exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
      exp_bu = '{1, 1, 1, 1, 3, 1};
      rst_n = 1'b0;
      req = '0; we = '0; burst = '0;
      for (int k = 0; k < N; k++) begin
         addr[k]  = '0;
         wdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_gnt",  64'(o_gnt), 64'(0));
      chk("reset_idx",  64'(o_gnt_idx), 64'(0));
      chk("reset_we",   64'(o_ram_we), 64'(0));
      chk("reset_addr", 64'(o_ram_addr), 64'(0));
      chk("reset_data", 64'(o_ram_data), 64'(0));
      chk("reset_busy", 64'(o_busy), 64'(0));
      step();
      rst_n = 1'b1;

      req = 4'b0100; we = '0; addr[2] = 4'd5;
      @(negedge clk);
      chk("single_gnt", 64'(o_gnt), 64'(4'b0100));
      step();
      req = '0;
      @(negedge clk);
      chk("single_rvalid", 64'(o_rvalid), 64'(4'b0100));
      chk("single_rdata", 64'(o_rdata), 64'(32'hDEADBEEF));

      do_reset();
      req = 4'b1111; burst = '0; we = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rr_idx", 64'(o_gnt_idx), 64'(exp_rr[i]));
         step();
      end
      req = '0;

      do_reset();
      req = 4'b1010; burst = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("burst_idx", 64'(o_gnt_idx), 64'(exp_bu[i]));
         step();
      end
      req = '0; burst = '0;

      do_reset();
      req = 4'b0001; we = 4'b0001; addr[0] = 4'd3; wdata[0] = 32'h12345678;
      step();
      req = 4'b0010; we = '0; addr[1] = 4'd3;
      @(negedge clk);
      chk("wr_rd_gnt", 64'(o_gnt), 64'(4'b0010));
      step();
      req = '0;
      @(negedge clk);
      chk("wr_rd_rvalid", 64'(o_rvalid), 64'(4'b0010));
      chk("wr_rd_rdata", 64'(o_rdata), 64'(32'h12345678));

      req = 4'b0010; we = '0; addr[1] = 4'd7;
      step();
      req = '0;
      chk("mid_rvalid", 64'(o_rvalid), 64'(4'b0010));
      rst_n = 1'b0;
      #1;
      chk("async_rvalid", 64'(o_rvalid), 64'(0));
      chk("async_busy", 64'(o_busy), 64'(0));
      step();
      rst_n = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      chk("post_rst_gnt", 64'(o_gnt), 64'(4'b0001));
      step();
      req = '0;

`ifdef ARB_STATS_EN
      do_reset();
      req = 4'b0111;
      repeat (6) step();
      req = '0;
      chk("stall_six", 64'(o_stall_cnt), 64'(6));
      do_reset();
      chk("stall_rst", 64'(o_stall_cnt), 64'(0));
`endif

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            req   = '0;
            step();
            rst_n = 1'b1;
         end
         for (int k = 0; k < N; k++) begin
            req[k]   = ($urandom_range(0, 3) != 0);
            we[k]    = 1'($urandom_range(0, 1));
            burst[k] = ($urandom_range(0, 3) != 0);
            addr[k]  = AW'($urandom_range(0, 15));
            wdata[k] = $urandom;
         end
         step();
      end
      req = '0;
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
